// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with registered one-hot grant,
// encoded index and bounded tenure per owner.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] owner, ptr, win;
    logic [3:0] hold_cnt, others;
    logic       expired, take;

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] s);
        pick = s;
        for (int k = 3; k >= 0; k--)
            if (r[s + 2'(k)]) pick = s + 2'(k);
    endfunction

    // While granted the search starts after the owner, so a pre-empting owner ranks last
    always_comb begin
        win     = pick(req, (state == GRANT) ? owner + 2'd1 : ptr);
        others  = req & ~(4'b0001 << owner);
        expired = hold_cnt == 4'(MAX_HOLD);
        take    = (state == IDLE) ? |req : (!req[owner] || expired) && |others;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 2'd0;
            ptr       <= 2'd0;
            hold_cnt  <= 4'd0;
            gnt       <= 4'd0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
        end else if (take) begin
            state     <= GRANT;
            owner     <= win;
            ptr       <= win + 2'd1;
            hold_cnt  <= 4'd1;
            gnt       <= 4'b0001 << win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
        end else if (state == GRANT && !req[owner]) begin
            state     <= IDLE;
            gnt       <= 4'd0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
        end else if (state == GRANT) begin
            hold_cnt  <= expired ? 4'd1 : hold_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: checks two arbiter instances (MAX_HOLD 8 and 2) against a
// behavioural round-robin model, plus directed literal expectations.
module tb_rr_arbiter4;
    logic       clk, rst_n, chk_en;
    logic [3:0] req;
    logic [3:0] gnt8, gnt2;
    logic [1:0] idx8, idx2;
    logic       val8, val2;
    int         vectors = 0, miscompares = 0;
    int         wt[2][4];
    int         mh[2] = '{8, 2};

    typedef struct {
        int own;
        int ptr;
        int cnt;
    } mst_t;

    mst_t ms[2];

    rr_arbiter4 #(.MAX_HOLD(8)) u8 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8));
    rr_arbiter4 #(.MAX_HOLD(2)) u2 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(val2));

    initial clk = 0;
    always #5 clk = ~clk;

    // One clock of the arbiter's behaviour; own = -1 means no grant
    function automatic mst_t step(mst_t s, logic [3:0] r, int m);
        mst_t n = s;
        int start = (s.own < 0) ? s.ptr : (s.own + 1) % 4;
        int w = -1;
        bit contested;
        for (int k = 0; k < 4; k++)
            if (w < 0 && r[(start + k) % 4]) w = (start + k) % 4;
        if (s.own < 0) begin
            if (w >= 0) begin
                n.own = w; n.cnt = 1; n.ptr = (w + 1) % 4;
            end
        end else begin
            contested = (r & ~(4'b0001 << s.own)) != 4'd0;
            if (contested && (!r[s.own] || s.cnt == m)) begin
                n.own = w; n.cnt = 1; n.ptr = (w + 1) % 4;
            end else if (!r[s.own]) n.own = -1;
            else n.cnt = (s.cnt == m) ? 1 : s.cnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) ms[d] <= '{-1, 0, 0};
        end else begin
            ms[0] <= step(ms[0], req, mh[0]);
            ms[1] <= step(ms[1], req, mh[1]);
        end
    end

    task automatic chk(string n, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", n, got, exp, $time);
        end
    endtask

    task automatic cmp(int d, logic [3:0] g, logic [1:0] ix, logic v);
        int eg = (ms[d].own < 0) ? 0 : (1 << ms[d].own);
        int ei = (ms[d].own < 0) ? 0 : ms[d].own;
        chk($sformatf("gnt[mh=%0d]", mh[d]), int'(g), eg);
        chk($sformatf("gnt_idx[mh=%0d]", mh[d]), int'(ix), ei);
        chk($sformatf("gnt_valid[mh=%0d]", mh[d]), int'(v), int'(ms[d].own >= 0));
        chk($sformatf("onehot[mh=%0d]", mh[d]), int'($countones(g) <= 1), 1);
        for (int i = 0; i < 4; i++) begin
            wt[d][i] = (req[i] && !g[i] && rst_n) ? wt[d][i] + 1 : 0;
            if (wt[d][i] > 3 * mh[d] + 1) chk($sformatf("starve%0d[mh=%0d]", i, mh[d]), wt[d][i], 3 * mh[d] + 1);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, gnt8, idx8, val8);
            cmp(1, gnt2, idx2, val2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int rot[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) wt[d][i] = 0;
        chk_en = 0; rst_n = 0; req = 4'd0;
        tick(); tick();
        rst_n = 1; chk_en = 1;
        tick();
        chk("reset gnt", int'(gnt8), 0);
        chk("reset idx", int'(idx8), 0);
        chk("reset valid", int'(val8), 0);
        req = 4'b0100;
        tick();
        chk("single gnt", int'(gnt8), 4);
        chk("single idx", int'(idx8), 2);
        chk("single valid", int'(val8), 1);
        repeat (3) tick();
        chk("single hold", int'(gnt8), 4);
        req = 4'b0001; tick();
        chk("handover to 0", int'(gnt8), 1);
        req = 4'b0000; tick();
        chk("idle gnt", int'(gnt8), 0);
        chk("idle idx", int'(idx8), 0);
        chk("idle valid", int'(val8), 0);
        req = 4'b0011; tick();
        chk("ptr1 pick", int'(gnt8), 2);
        req = 4'b1010; tick();
        chk("owner1 hold", int'(gnt8), 2);
        req = 4'b1000; tick();
        chk("release gnt", int'(gnt8), 8);
        chk("release idx", int'(idx8), 3);
        req = 4'b0001; tick();
        for (int c = 0; c < 20; c++) chk("sole owner", int'(gnt8), 1);
        for (int c = 0; c < 20; c++) tick();
        chk("sole owner end", int'(gnt8), 1);
        req = 4'b0010; tick();
        chk("pre-reset gnt", int'(gnt8), 2);
        #1 rst_n = 0;
        #1;
        chk("async gnt", int'(gnt8), 0);
        chk("async valid", int'(val8), 0);
        chk("async gnt2", int'(gnt2), 0);
        rst_n = 1; req = 4'b1111;
        tick();
        chk("post-reset gnt", int'(gnt8), 1);
        chk("rot start", int'(idx2), 0);
        foreach (rot[i]) begin
            tick();
            chk("rot idx", int'(idx2), rot[i]);
            chk("rot valid", int'(val2), 1);
        end
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            tick();
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
